// File: rtl/dp_seq_feeder_pkg.sv
// Shared types and constants for the DP sequence feeder.
package dp_seq_feeder_pkg;

    localparam int BP_W       = 2;
    localparam int LEN_W      = 12;
    localparam int N_DEF      = 8;
    localparam int LOG_N_DEF  = 3;
    localparam int MEM_AW_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEWSEQ,
        ST_LOAD_S,
        ST_SUPD,
        ST_GAP,
        ST_STREAM_T,
        ST_WAIT,
        ST_FIN
    } state_t;

    // Number of N-base chunks needed to cover len bases. The sum is computed
    // one bit wider so that len = 2^LEN_W-1 does not overflow.
    function automatic logic [LEN_W-1:0] chunk_count(input logic [LEN_W-1:0] len, input int n);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(n - 1);
        return LEN_W'(sum / (LEN_W+1)'(n));
    endfunction

endpackage

// File: rtl/dp_feed_addr_gen.sv
// Sequence RAM read-address counter. Counts down through an S chunk or up
// through T; a read is suppressed (and pad raised) once the index reaches
// the active sequence length.
module dp_feed_addr_gen
    import dp_seq_feeder_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              ld,
    input  logic [LEN_W:0]    ld_val,
    input  logic              sel_t,
    input  logic              en,
    input  logic [MEM_AW-1:0] s_base,
    input  logic [MEM_AW-1:0] t_base,
    input  logic [LEN_W-1:0]  s_len,
    input  logic [LEN_W-1:0]  t_len,
    output logic              rd,
    output logic [MEM_AW-1:0] addr,
    output logic              pad
);

    logic [LEN_W:0]    idx;
    logic [LEN_W:0]    limit;
    logic [MEM_AW-1:0] base;
    logic [MEM_AW-1:0] offs;

    assign limit = {1'b0, (sel_t ? t_len : s_len)};
    assign pad   = (idx >= limit);
    assign rd    = en && !pad;
    assign base  = sel_t ? t_base : s_base;
    assign offs  = MEM_AW'(idx);
    // Address wraps modulo 2^MEM_AW; driven to zero when no read is issued.
    assign addr  = rd ? (base + offs) : '0;

    // Index register: load at chunk/stream start, then step once per enabled cycle.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            idx <= '0;
        end else if (ld) begin
            idx <= ld_val;
        end else if (en) begin
            idx <= sel_t ? (idx + 1'b1) : (idx - 1'b1);
        end
    end

endmodule

// File: rtl/dp_seq_feeder.sv
// DP systolic array load initiator: walks S in N-base chunks (descending),
// latches each chunk, then streams T, waiting for DP busy to clear between chunks.
//
//  state       | meaning
//  ------------+-------------------------------------------------------------
//  ST_IDLE     | waiting for start; latches job parameters
//  ST_NEWSEQ   | new_seq pulse for the sequence pair
//  ST_LOAD_S   | N+1 cycles: read/present chunk bases, highest index first
//  ST_SUPD     | s_update pulse, ack low
//  ST_GAP      | prefetch read of T[0]
//  ST_STREAM_T | t_len cycles of valid T
//  ST_WAIT     | hold until DP busy is sampled low
//  ST_FIN      | done pulse (err for a zero-length job)
module dp_seq_feeder
    import dp_seq_feeder_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int LOG_N  = LOG_N_DEF,
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              start,
    input  logic [MEM_AW-1:0] s_base,
    input  logic [LEN_W-1:0]  s_len,
    input  logic [MEM_AW-1:0] t_base,
    input  logic [LEN_W-1:0]  t_len,
    output logic              job_busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [BP_W-1:0]   mem_rdata,
    output logic              new_seq,
    output logic              ack,
    output logic [LOG_N-1:0]  PE_end,
    output logic [BP_W-1:0]   S,
    output logic              s_update,
    output logic [BP_W-1:0]   T,
    output logic              valid,
    input  logic              busy
);

    state_t            state, state_nx;
    logic [MEM_AW-1:0] s_base_r, t_base_r;
    logic [LEN_W-1:0]  s_len_r, t_len_r;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  chunks_left;
    logic [LEN_W:0]    chunk_base;
    logic              err_r;
    logic              pad_d;
    logic [BP_W-1:0]   s_hold, t_hold;

    logic              accept, zero_job, to_load;
    logic              ld, ag_en, sel_t, ag_pad, s_live;
    logic [LEN_W:0]    ld_val, next_base, rem, rem_m1;

    assign zero_job  = (s_len == '0) || (t_len == '0);
    assign next_base = (state == ST_WAIT) ? (chunk_base + (LEN_W+1)'(N)) : '0;
    assign rem       = {1'b0, s_len_r} - next_base;
    assign rem_m1    = rem - 1'b1;

    assign job_busy = (state != ST_IDLE);
    assign done     = (state == ST_FIN);
    assign err      = (state == ST_FIN) && err_r;
    assign new_seq  = (state == ST_NEWSEQ);
    assign s_update = (state == ST_SUPD);
    assign valid    = (state == ST_STREAM_T);
    assign ack      = (state inside {ST_LOAD_S, ST_GAP, ST_STREAM_T, ST_WAIT}) ||
                      ((state == ST_FIN) && !err_r);

    // RAM data arrives one cycle after the read, so S and T pass it straight
    // through while qualified and otherwise hold their last value.
    assign s_live = (state == ST_LOAD_S) && (cnt != LEN_W'(N));
    assign S      = s_live ? (pad_d ? '0 : mem_rdata) : s_hold;
    assign T      = valid ? mem_rdata : t_hold;

    dp_feed_addr_gen #(
        .MEM_AW (MEM_AW)
    ) u_addr_gen (
        .clk     (clk),
        .reset_i (reset_i),
        .ld      (ld),
        .ld_val  (ld_val),
        .sel_t   (sel_t),
        .en      (ag_en),
        .s_base  (s_base_r),
        .t_base  (t_base_r),
        .s_len   (s_len_r),
        .t_len   (t_len_r),
        .rd      (mem_rd),
        .addr    (mem_addr),
        .pad     (ag_pad)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and address-generator control.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        to_load  = 1'b0;
        ld       = 1'b0;
        ld_val   = next_base + (LEN_W+1)'(N - 1);
        ag_en    = 1'b0;
        sel_t    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = zero_job ? ST_FIN : ST_NEWSEQ;
                end
            end
            ST_NEWSEQ: begin
                to_load  = 1'b1;
                ld       = 1'b1;
                state_nx = ST_LOAD_S;
            end
            ST_LOAD_S: begin
                ag_en = (cnt != '0);
                if (cnt == '0) state_nx = ST_SUPD;
            end
            ST_SUPD: begin
                ld       = 1'b1;
                ld_val   = '0;
                state_nx = ST_GAP;
            end
            ST_GAP: begin
                sel_t    = 1'b1;
                ag_en    = 1'b1;
                state_nx = ST_STREAM_T;
            end
            ST_STREAM_T: begin
                sel_t = 1'b1;
                ag_en = 1'b1;
                if (cnt == '0) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (!busy) begin
                    if (chunks_left != LEN_W'(1)) begin
                        to_load  = 1'b1;
                        ld       = 1'b1;
                        state_nx = ST_LOAD_S;
                    end else begin
                        state_nx = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Job parameters, chunk tracking, cycle down-counter and output hold registers.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            s_base_r    <= '0;
            t_base_r    <= '0;
            s_len_r     <= '0;
            t_len_r     <= '0;
            err_r       <= 1'b0;
            chunks_left <= '0;
            chunk_base  <= '0;
            cnt         <= '0;
            PE_end      <= '0;
            pad_d       <= 1'b0;
            s_hold      <= '0;
            t_hold      <= '0;
        end else begin
            s_hold <= S;
            t_hold <= T;
            pad_d  <= ag_pad;
            if (accept) begin
                s_base_r    <= s_base;
                t_base_r    <= t_base;
                s_len_r     <= s_len;
                t_len_r     <= t_len;
                err_r       <= zero_job;
                chunks_left <= chunk_count(s_len, N);
                chunk_base  <= '0;
            end
            if (to_load) begin
                chunk_base <= next_base;
                cnt        <= LEN_W'(N);
                PE_end     <= (rem >= (LEN_W+1)'(N)) ? LOG_N'(N - 1) : LOG_N'(rem_m1);
                if (state == ST_WAIT) chunks_left <= chunks_left - 1'b1;
            end else if (state == ST_SUPD) begin
                cnt <= t_len_r - 1'b1;
            end else if (((state == ST_LOAD_S) || (state == ST_STREAM_T)) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dp_seq_feeder.sv
// Directed bench for dp_seq_feeder with a registered-read RAM model and a DP busy model.
module tb_dp_seq_feeder;
    import dp_seq_feeder_pkg::*;

    localparam int N      = 8;
    localparam int LOG_N  = 3;
    localparam int MEM_AW = 10;

    logic              clk = 1'b0;
    logic              reset_i = 1'b0;
    logic              start = 1'b0;
    logic [MEM_AW-1:0] s_base = '0;
    logic [LEN_W-1:0]  s_len = '0;
    logic [MEM_AW-1:0] t_base = '0;
    logic [LEN_W-1:0]  t_len = '0;
    logic              job_busy, done, err, mem_rd, new_seq, ack, s_update, valid;
    logic [MEM_AW-1:0] mem_addr;
    logic [BP_W-1:0]   mem_rdata = '0;
    logic [LOG_N-1:0]  PE_end;
    logic [BP_W-1:0]   S, T;
    logic              busy = 1'b0;

    int total = 0;
    int bad = 0;

    dp_seq_feeder #(.N(N), .LOG_N(LOG_N), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset_i(reset_i), .start(start),
        .s_base(s_base), .s_len(s_len), .t_base(t_base), .t_len(t_len),
        .job_busy(job_busy), .done(done), .err(err),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .new_seq(new_seq), .ack(ack), .PE_end(PE_end), .S(S),
        .s_update(s_update), .T(T), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [BP_W-1:0] mem [0:(1<<MEM_AW)-1];

    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // Observation state, updated at the falling edge.
    int cyc = 0;
    int n_newseq, n_supd, n_valid, n_rd, n_done, n_err;
    int last_valid_cyc, done_gap, ack_supd_hi, ack_stream_lo;
    int busy_tail, tail_cnt;
    logic [15:0]      s_hist;
    logic [15:0]      s_obs [4];
    logic [LOG_N-1:0] pe_obs [4];
    logic [BP_W-1:0]  supd_s [4];
    int               gap [4];
    logic [31:0]      t_vec [4];

    always @(negedge clk) begin
        cyc++;
        if (new_seq) n_newseq++;
        if (mem_rd) n_rd++;
        if (s_update) begin
            if (n_supd < 4) begin
                s_obs[n_supd]  = s_hist;
                pe_obs[n_supd] = PE_end;
                supd_s[n_supd] = S;
                t_vec[n_supd]  = '0;
                if (n_supd > 0) gap[n_supd] = cyc - 9 - last_valid_cyc;
            end
            if (ack) ack_supd_hi++;
            n_supd++;
        end
        s_hist = {s_hist[13:0], S};
        if (valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (!ack) ack_stream_lo++;
            if (n_supd >= 1 && n_supd <= 4) t_vec[n_supd-1] = {t_vec[n_supd-1][29:0], T};
        end
        if (done) begin
            n_done++;
            if (err) n_err++;
            done_gap = cyc - last_valid_cyc;
        end
        if (valid) begin
            busy = 1'b1;
            tail_cnt = busy_tail;
        end else if (tail_cnt == 0) begin
            busy = 1'b0;
        end else begin
            tail_cnt--;
        end
    end

    task automatic clear_stats();
        n_newseq = 0; n_supd = 0; n_valid = 0; n_rd = 0; n_done = 0; n_err = 0;
        last_valid_cyc = 0; done_gap = -1; ack_supd_hi = 0; ack_stream_lo = 0;
        tail_cnt = 0; busy = 1'b0; s_hist = '0;
        for (int i = 0; i < 4; i++) begin
            s_obs[i] = '0; pe_obs[i] = '0; supd_s[i] = '0; gap[i] = -1; t_vec[i] = '0;
        end
    endtask

    // Expected S presentation for chunk j: index j*8+7 down to j*8, zero past s_len.
    function automatic logic [15:0] exp_s(input logic [MEM_AW-1:0] sb, input int sl, input int j);
        logic [15:0] v;
        logic [BP_W-1:0] b;
        int idx;
        v = '0;
        for (int k = 0; k < 8; k++) begin
            idx = j * 8 + 7 - k;
            b = (idx < sl) ? mem[sb + MEM_AW'(idx)] : '0;
            v = {v[13:0], b};
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_t(input logic [MEM_AW-1:0] tb_a, input int tl);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < tl; i++) v = {v[29:0], mem[tb_a + MEM_AW'(i)]};
        return v;
    endfunction

    task automatic run_job(input logic [MEM_AW-1:0] sb, input int sl,
                           input logic [MEM_AW-1:0] tb_a, input int tl,
                           input int tail, input string name);
        @(posedge clk); #1;
        clear_stats();
        busy_tail = tail;
        s_base = sb; s_len = LEN_W'(sl); t_base = tb_a; t_len = LEN_W'(tl);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3000 && n_done == 0; i++) @(negedge clk);
        total++;
        if (n_done != 1) begin
            bad++;
            $display("FAIL %s_done_seen: got %0d want 1", name, n_done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({job_busy, done, err, mem_rd, new_seq, ack, s_update, valid} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {job_busy, done, err, mem_rd, new_seq, ack, s_update, valid});
        end
        total++;
        if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0h want 0", mem_addr); end
        total++;
        if ({S, T} !== 4'h0) begin bad++; $display("FAIL reset_st: got %b want 0000", {S, T}); end
        total++;
        if (PE_end !== '0) begin bad++; $display("FAIL reset_pe_end: got %0d want 0", PE_end); end
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (job_busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got %b want 0", job_busy); end
    endtask

    task automatic test_single_chunk();
        run_job(10'd100, 5, 10'd200, 4, 0, "single");
        total++;
        if (n_newseq != 1) begin bad++; $display("FAIL single_newseq: got %0d want 1", n_newseq); end
        total++;
        if (n_supd != 1) begin bad++; $display("FAIL single_supd: got %0d want 1", n_supd); end
        total++;
        if (pe_obs[0] !== 3'd4) begin bad++; $display("FAIL single_pe_end: got %0d want 4", pe_obs[0]); end
        total++;
        if (s_obs[0] !== exp_s(10'd100, 5, 0)) begin
            bad++; $display("FAIL single_s_order: got %h want %h", s_obs[0], exp_s(10'd100, 5, 0));
        end
        total++;
        if (supd_s[0] !== mem[100]) begin bad++; $display("FAIL single_s_at_supd: got %0d want %0d", supd_s[0], mem[100]); end
        total++;
        if (n_valid != 4) begin bad++; $display("FAIL single_valid_cnt: got %0d want 4", n_valid); end
        total++;
        if (t_vec[0] !== exp_t(10'd200, 4)) begin
            bad++; $display("FAIL single_t_data: got %h want %h", t_vec[0], exp_t(10'd200, 4));
        end
        total++;
        if (n_rd != 9) begin bad++; $display("FAIL single_reads: got %0d want 9", n_rd); end
        total++;
        if (n_err != 0) begin bad++; $display("FAIL single_err: got %0d want 0", n_err); end
        total++;
        if (ack_supd_hi != 0 || ack_stream_lo != 0) begin
            bad++; $display("FAIL single_ack: supd_hi=%0d stream_lo=%0d want 0 0", ack_supd_hi, ack_stream_lo);
        end
    endtask

    task automatic test_multi_chunk();
        run_job(10'd300, 20, 10'd40, 3, 2, "multi");
        total++;
        if (n_supd != 3) begin bad++; $display("FAIL multi_chunks: got %0d want 3", n_supd); end
        total++;
        if ({pe_obs[0], pe_obs[1], pe_obs[2]} !== {3'd7, 3'd7, 3'd3}) begin
            bad++; $display("FAIL multi_pe_end: got %0d,%0d,%0d want 7,7,3", pe_obs[0], pe_obs[1], pe_obs[2]);
        end
        for (int j = 0; j < 3; j++) begin
            total++;
            if (s_obs[j] !== exp_s(10'd300, 20, j)) begin
                bad++; $display("FAIL multi_s_chunk%0d: got %h want %h", j, s_obs[j], exp_s(10'd300, 20, j));
            end
        end
        total++;
        if (gap[1] != 4 || gap[2] != 4) begin
            bad++; $display("FAIL multi_wait_gap: got %0d,%0d want 4,4", gap[1], gap[2]);
        end
        total++;
        if (done_gap != 4) begin bad++; $display("FAIL multi_done_gap: got %0d want 4", done_gap); end
        total++;
        if (n_valid != 9) begin bad++; $display("FAIL multi_valid_cnt: got %0d want 9", n_valid); end
        total++;
        if (t_vec[2] !== exp_t(10'd40, 3)) begin
            bad++; $display("FAIL multi_t_data: got %h want %h", t_vec[2], exp_t(10'd40, 3));
        end
        total++;
        if (n_rd != 29) begin bad++; $display("FAIL multi_reads: got %0d want 29", n_rd); end
    endtask

    task automatic test_exact16();
        run_job(10'd1020, 16, 10'd500, 2, 0, "exact16");
        total++;
        if ({pe_obs[0], pe_obs[1]} !== {3'd7, 3'd7} || n_supd != 2) begin
            bad++; $display("FAIL exact16_pe_end: got %0d,%0d (%0d chunks) want 7,7 (2)", pe_obs[0], pe_obs[1], n_supd);
        end
        total++;
        if (s_obs[0] !== exp_s(10'd1020, 16, 0) || s_obs[1] !== exp_s(10'd1020, 16, 1)) begin
            bad++; $display("FAIL exact16_s_wrap: got %h,%h want %h,%h", s_obs[0], s_obs[1],
                            exp_s(10'd1020, 16, 0), exp_s(10'd1020, 16, 1));
        end
        total++;
        if (n_rd != 20) begin bad++; $display("FAIL exact16_reads: got %0d want 20", n_rd); end
    endtask

    task automatic test_zero_len();
        run_job(10'd0, 5, 10'd0, 0, 0, "tlen0");
        total++;
        if (n_err != 1) begin bad++; $display("FAIL tlen0_err: got %0d want 1", n_err); end
        total++;
        if (n_newseq != 0 || n_valid != 0 || n_rd != 0) begin
            bad++; $display("FAIL tlen0_traffic: newseq=%0d valid=%0d rd=%0d want 0 0 0", n_newseq, n_valid, n_rd);
        end
        run_job(10'd0, 0, 10'd0, 4, 0, "slen0");
        total++;
        if (n_err != 1 || n_newseq != 0 || n_rd != 0) begin
            bad++; $display("FAIL slen0: err=%0d newseq=%0d rd=%0d want 1 0 0", n_err, n_newseq, n_rd);
        end
    endtask

    task automatic test_start_ignored();
        int i;
        @(posedge clk); #1;
        clear_stats();
        busy_tail = 0;
        s_base = 10'd10; s_len = 12'd5; t_base = 10'd20; t_len = 12'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (i = 0; i < 200; i++) begin @(negedge clk); if (valid) break; end
        total++;
        if (i >= 200) begin bad++; $display("FAIL ign_reach_stream: got timeout want valid"); end
        s_len = 12'd3; t_len = 12'd2; s_base = 10'd700;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (i = 0; i < 500; i++) begin @(negedge clk); if (done) break; end
        total++;
        if (i >= 500) begin bad++; $display("FAIL ign_done: got timeout want done"); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (n_newseq != 1) begin bad++; $display("FAIL ign_newseq: got %0d want 1", n_newseq); end
        total++;
        if (n_valid != 6 || t_vec[0] !== exp_t(10'd20, 6)) begin
            bad++; $display("FAIL ign_t: got %0d/%h want 6/%h", n_valid, t_vec[0], exp_t(10'd20, 6));
        end
        total++;
        if (pe_obs[0] !== 3'd4) begin bad++; $display("FAIL ign_pe_end: got %0d want 4", pe_obs[0]); end
        total++;
        if (job_busy !== 1'b0 || n_done != 1) begin
            bad++; $display("FAIL ign_done_start: busy=%b dones=%0d want 0 1", job_busy, n_done);
        end
    endtask

    task automatic test_busy_hold();
        run_job(10'd600, 10, 10'd700, 2, 50, "busyhold");
        total++;
        if (n_supd != 2 || pe_obs[1] !== 3'd1) begin
            bad++; $display("FAIL busyhold_chunks: got %0d/pe %0d want 2/pe 1", n_supd, pe_obs[1]);
        end
        total++;
        if (gap[1] != 52) begin bad++; $display("FAIL busyhold_wait: got %0d want 52", gap[1]); end
        total++;
        if (done_gap != 52) begin bad++; $display("FAIL busyhold_done_gap: got %0d want 52", done_gap); end
        total++;
        if (n_valid != 4) begin bad++; $display("FAIL busyhold_valid_cnt: got %0d want 4", n_valid); end
    endtask

    task automatic test_reset_mid();
        int i;
        @(posedge clk); #1;
        clear_stats();
        busy_tail = 0;
        s_base = 10'd50; s_len = 12'd5; t_base = 10'd60; t_len = 12'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (i = 0; i < 200; i++) begin @(negedge clk); if (valid) break; end
        @(negedge clk);
        total++;
        if (valid !== 1'b1) begin bad++; $display("FAIL rstmid_in_stream: got %b want 1", valid); end
        reset_i = 1'b0;
        #1;
        total++;
        if ({job_busy, valid, ack, mem_rd, new_seq, s_update, done} !== 7'h00 || T !== 2'd0 || PE_end !== '0) begin
            bad++; $display("FAIL rstmid_outputs: got %b T=%0d pe=%0d want 0",
                            {job_busy, valid, ack, mem_rd, new_seq, s_update, done}, T, PE_end);
        end
        repeat (3) @(negedge clk);
        reset_i = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (n_done != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", n_done); end
        run_job(10'd100, 5, 10'd200, 4, 0, "postrst");
        total++;
        if (n_newseq != 1 || pe_obs[0] !== 3'd4 || s_obs[0] !== exp_s(10'd100, 5, 0)) begin
            bad++; $display("FAIL postrst_s: newseq=%0d pe=%0d s=%h want 1 4 %h", n_newseq, pe_obs[0], s_obs[0],
                            exp_s(10'd100, 5, 0));
        end
        total++;
        if (t_vec[0] !== exp_t(10'd200, 4) || n_rd != 9) begin
            bad++; $display("FAIL postrst_t: got %h rd=%0d want %h rd=9", t_vec[0], n_rd, exp_t(10'd200, 4));
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = BP_W'((i * 3) ^ (i >> 3));
        clear_stats();
        busy_tail = 0;
        test_reset();
        test_single_chunk();
        test_multi_chunk();
        test_exact16();
        test_zero_len();
        test_start_ignored();
        test_busy_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit want finish");
        $fatal(1, "watchdog");
    end

endmodule
